// File: rtl/vga_scan_driver.sv
// ---------------------------------------------------------------------------
// vga_scan_driver
//
// VGA timing master. It presents pixel scan coordinates (xpos, ypos) to the
// maze/sprite renderer and takes back the renderer's 8-bit RGB 3-3-2 color.
// Blanking and sync are delayed by the renderer's pixel latency, so color,
// sync and blank reach the DAC pins on the same pixel tick.
//
// Optional build macro: VGA_TESTPAT_EN
//   When defined, a test_mode input is added. With test_mode=1 the color
//   input is ignored and eight full-scale vertical colour bars are shown.
//   The bars go through the same latency alignment and blanking as color.
//
// Parameters
//   CLK_DIV             clk cycles per pixel tick (>= 1)
//   PIX_LAT             pixel ticks from xpos/ypos to valid color (0..4)
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal timing in pixel ticks
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical timing in lines
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   test_mode    colour-bar select (VGA_TESTPAT_EN builds only)
//   color[7:0]   renderer color, [7:5]=R [4:2]=G [1:0]=B
//   xpos[9:0]    current horizontal count, blanking values included
//   ypos[9:0]    current vertical count, blanking values included
//   active       xpos/ypos inside the visible area (undelayed)
//   pix_tick     one-clk strobe, counters advance on it
//   frame_start  one-clk pulse when the counters enter (0,0)
//   hsync/vsync  active-low syncs, delayed by PIX_LAT ticks
//   vga_r/g/b    4-bit colour components to the DAC
// ---------------------------------------------------------------------------
module vga_scan_driver #(
  parameter int CLK_DIV  = 2,
  parameter int PIX_LAT  = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
`ifdef VGA_TESTPAT_EN
  input  logic       test_mode,
`endif
  input  logic [7:0] color,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       active,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Pipeline word: {active, hs_raw, vs_raw}, plus the bar index when the
  // test pattern is built in.
`ifdef VGA_TESTPAT_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int PW    = 6;
`else
  localparam int PW    = 3;
`endif

  // Blank with both syncs inactive (high).
  localparam logic [PW-1:0] IDLE = PW'(3'b011);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             h_last;
  logic             v_last;
  logic             hs_raw;
  logic             vs_raw;
  logic [PW-1:0]    raw_bus;
  logic [PW-1:0]    dly;
  logic [11:0]      pix_rgb;
  logic [11:0]      rgb;

  // Clock divider. pix_tick is registered so it stays low throughout reset
  // even when CLK_DIV=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      pix_tick <= (div == DIV_W'(CLK_DIV - 1));
      if (div == DIV_W'(CLK_DIV - 1))
        div <= '0;
      else
        div <= div + DIV_W'(1);
    end
  end

  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  // Scan counters. frame_start is raised on the same edge that loads (0,0),
  // so it is high during the first clk in which the counters read (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        if (h_last) begin
          h_cnt       <= '0;
          v_cnt       <= v_last ? 10'd0 : v_cnt + 10'd1;
          frame_start <= v_last;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign xpos = h_cnt;
  assign ypos = v_cnt;

  // Gated by rst so active reads 0 while reset is held even though the
  // counters then sit at (0,0), which lies inside the visible area.
  assign active = rst && (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign hs_raw = !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
  assign vs_raw = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));

`ifdef VGA_TESTPAT_EN
  assign raw_bus = {3'(h_cnt / 10'(BAR_W)), active, hs_raw, vs_raw};
`else
  assign raw_bus = {active, hs_raw, vs_raw};
`endif

  // Latency-matching delay line for blank/sync, advanced on pix_tick.
  generate
    if (PIX_LAT == 0) begin : g_nolat
      assign dly = raw_bus;
    end else begin : g_lat
      logic [PW-1:0] pipe [PIX_LAT];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIX_LAT; i++)
            pipe[i] <= IDLE;
        end else if (pix_tick) begin
          pipe[0] <= raw_bus;
          for (int i = 1; i < PIX_LAT; i++)
            pipe[i] <= pipe[i-1];
        end
      end

      assign dly = pipe[PIX_LAT-1];
    end
  endgenerate

  // 3-3-2 to 4-4-4 by replicating the top bits, so full scale maps to 4'hF.
  // Bar colours: R on bars 0,1,4,5; G on bars 0..3; B on even bars.
  always_comb begin
    pix_rgb = {color[7:5], color[7], color[4:2], color[4], color[1:0], color[1:0]};
`ifdef VGA_TESTPAT_EN
    if (test_mode)
      pix_rgb = {{4{~dly[4]}}, {4{~dly[5]}}, {4{~dly[3]}}};
`endif
  end

  // Output register: color is sampled on the same tick the delay line shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else if (pix_tick) begin
      hsync <= dly[1];
      vsync <= dly[0];
      rgb   <= dly[2] ? pix_rgb : 12'h000;
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule
